// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles every non-clock signal of the UART transmit arbiter.
//
// The "slave" modport is the arbiter itself. The "master" modport is its
// environment: the requesters together with the downstream UART controller.
//
//   req               master->slave  per-requester request level
//   req_data          master->slave  per-requester word, requester i at
//                                    [i*BYTES*8 +: BYTES*8]
//   ctrl_tx_busy      master->slave  controller busy flag (tx_busy_total)
//   grant_ack         slave->master  one-cycle pulse, word of requester i latched
//   tx_done           slave->master  one-cycle pulse, word of requester i sent
//   tx_err            slave->master  one-cycle pulse, controller never went busy
//   ctrl_data_to_send slave->master  latched word driven to the controller
//   ctrl_start_tx     slave->master  one-cycle start pulse to the controller
//   arb_busy          slave->master  arbiter is not idle
//   last_grant        slave->master  index of the most recent grant
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int BYTES = 2
);
    localparam int LG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]         req;
    logic [N_REQ*BYTES*8-1:0] req_data;
    logic                     ctrl_tx_busy;
    logic [N_REQ-1:0]         grant_ack;
    logic [N_REQ-1:0]         tx_done;
    logic [N_REQ-1:0]         tx_err;
    logic [BYTES*8-1:0]       ctrl_data_to_send;
    logic                     ctrl_start_tx;
    logic                     arb_busy;
    logic [LG_W-1:0]          last_grant;

    modport master (
        output req, req_data, ctrl_tx_busy,
        input  grant_ack, tx_done, tx_err, ctrl_data_to_send,
               ctrl_start_tx, arb_busy, last_grant
    );

    modport slave (
        input  req, req_data, ctrl_tx_busy,
        output grant_ack, tx_done, tx_err, ctrl_data_to_send,
               ctrl_start_tx, arb_busy, last_grant
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one multi-byte UART transmit controller among
// N_REQ requesters. A granted requester's word is latched and handed to the
// controller together with a one-cycle start pulse; the arbiter then follows
// the controller's busy flag and reports completion (tx_done) or a timeout
// (tx_err, controller never went busy) back to the granted requester.
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    uart_tx_arbiter_if.slave (requester and controller signals)
//
// Parameters:
//   N_REQ    number of requesters (>= 2)
//   BYTES    word width in bytes, equal to the controller's width
//   TIMEOUT  cycles allowed for the busy flag to rise after start (>= 2)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int BYTES   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_arbiter_if.slave    bus
);
    localparam int W    = BYTES * 8;
    localparam int LG_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW   = $clog2(TIMEOUT + 1);

    localparam logic [N_REQ-1:0] ONE_HOT_0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [LG_W-1:0]  LAST_IDX  = LG_W'(N_REQ - 1);
    localparam logic [TW-1:0]    TIMER_END = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [TW-1:0]     timer_r;
    logic [LG_W-1:0]   last_grant_r;
    logic [N_REQ-1:0]  grant_ack_r;
    logic [N_REQ-1:0]  tx_done_r;
    logic [N_REQ-1:0]  tx_err_r;
    logic [W-1:0]      data_r;
    logic              start_r;
    logic              arb_busy_r;

    logic              pick_valid_s;
    logic [LG_W-1:0]   pick_idx_s;
    logic [LG_W-1:0]   cand_s;
    logic [W-1:0]      data_sel_s;

    // Round-robin search: walk from the farthest candidate back to the one
    // just after last_grant so that the nearest requesting index wins.
    always_comb begin
        pick_valid_s = 1'b0;
        pick_idx_s   = '0;
        cand_s       = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand_s       = LG_W'((int'(last_grant_r) + off) % N_REQ);
            pick_valid_s = bus.req[cand_s] ? 1'b1 : pick_valid_s;
            pick_idx_s   = bus.req[cand_s] ? cand_s : pick_idx_s;
        end
    end

    // Word of the selected requester, ready to be latched on the grant edge.
    always_comb begin
        data_sel_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            data_sel_s = (pick_idx_s == LG_W'(i)) ? bus.req_data[i*W +: W] : data_sel_s;
        end
    end

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            timer_r      <= '0;
            last_grant_r <= LAST_IDX;
            grant_ack_r  <= '0;
            tx_done_r    <= '0;
            tx_err_r     <= '0;
            data_r       <= '0;
            start_r      <= 1'b0;
            arb_busy_r   <= 1'b0;
        end else begin
            // Pulses default low; the state below raises at most one of them.
            grant_ack_r <= '0;
            tx_done_r   <= '0;
            tx_err_r    <= '0;
            start_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // ctrl_tx_busy is deliberately not consulted here.
                    if (pick_valid_s) begin
                        data_r       <= data_sel_s;
                        last_grant_r <= pick_idx_s;
                        grant_ack_r  <= ONE_HOT_0 << pick_idx_s;
                        start_r      <= 1'b1;
                        timer_r      <= '0;
                        state_r      <= ST_WAIT_BUSY;
                        arb_busy_r   <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        arb_busy_r   <= 1'b0;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (bus.ctrl_tx_busy) begin
                        state_r    <= ST_WAIT_DONE;
                        arb_busy_r <= 1'b1;
                    end else if (timer_r == TIMER_END) begin
                        // The last allowed cycle passed with busy still low.
                        tx_err_r   <= ONE_HOT_0 << last_grant_r;
                        state_r    <= ST_IDLE;
                        arb_busy_r <= 1'b0;
                    end else begin
                        // Leaving at TIMER_END keeps the timer from wrapping.
                        timer_r    <= timer_r + TW'(1);
                        arb_busy_r <= 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.ctrl_tx_busy) begin
                        tx_done_r  <= ONE_HOT_0 << last_grant_r;
                        state_r    <= ST_IDLE;
                        arb_busy_r <= 1'b0;
                    end else begin
                        state_r    <= ST_WAIT_DONE;
                        arb_busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    arb_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant_ack         = grant_ack_r;
    assign bus.tx_done           = tx_done_r;
    assign bus.tx_err            = tx_err_r;
    assign bus.ctrl_data_to_send = data_r;
    assign bus.ctrl_start_tx     = start_r;
    assign bus.arb_busy          = arb_busy_r;
    assign bus.last_grant        = last_grant_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench: directed scenarios followed by randomized traffic.
// The reference model keeps the set of pending requesters, their words and
// the round-robin pointer; a controller model raises/drops busy after a
// chosen delay and length. Each transaction's expected output timeline is
// derived from those rules and compared cycle by cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int B  = 2;
    localparam int W  = B * 8;
    localparam int TO = 15;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0] pending;
    logic [W-1:0] words [N];
    int           waits [N];
    int           model_last;

    uart_tx_arbiter_if #(.N_REQ(N), .BYTES(B)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .BYTES(B), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First pending requester after 'last', wrapping around.
    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int off = 1; off <= N; off++) begin
            if (m[(last + off) % N]) return (last + off) % N;
        end
        return -1;
    endfunction

    task automatic drive_req();
        bus.req = pending;
        for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = words[i];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pending = '0;
        drive_req();
        bus.ctrl_tx_busy = 1'b0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        @(posedge clk);
        @(negedge clk);
        check_val("rst_grant_ack", bus.grant_ack, '0);
        check_val("rst_tx_done", bus.tx_done, '0);
        check_val("rst_tx_err", bus.tx_err, '0);
        check_val("rst_start", bus.ctrl_start_tx, 1'b0);
        check_val("rst_data", bus.ctrl_data_to_send, '0);
        check_val("rst_arb_busy", bus.arb_busy, 1'b0);
        check_val("rst_last_grant", bus.last_grant, N - 1);
        reset = 1'b0;
        model_last = N - 1;
    endtask

    task automatic idle_quiet(input int n);
        pending = '0;
        drive_req();
        bus.ctrl_tx_busy = 1'b0;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("idle_grant_ack", bus.grant_ack, '0);
            check_val("idle_tx_done", bus.tx_done, '0);
            check_val("idle_tx_err", bus.tx_err, '0);
            check_val("idle_start", bus.ctrl_start_tx, 1'b0);
            check_val("idle_arb_busy", bus.arb_busy, 1'b0);
        end
    endtask

    // Called at the falling edge of a cycle in which the arbiter is idle.
    // d < 0: busy never rises; otherwise busy is high for cycles d..d+len-1
    // counted from the start-pulse cycle (t=0). Returns at the falling edge
    // of the tx_done / tx_err cycle, which is again an idle cycle.
    task automatic run_txn(input int d, input int len, input bit hold, input bit chg, output int obs);
        int           exp_idx;
        int           end_t;
        bit           seen;
        logic [W-1:0] latched;
        logic [N-1:0] oh;
        logic [N-1:0] snap;
        if (pending == '0) pending[0] = 1'b1;
        drive_req();
        snap    = pending;
        exp_idx = rr_pick(pending, model_last);
        latched = words[exp_idx];
        oh      = N'(1) << exp_idx;
        seen    = (d >= 0) && (d <= TO - 1) && (len >= 1);
        end_t   = seen ? (d + len + 1) : TO;
        obs     = -1;
        @(posedge clk);
        @(negedge clk);
        for (int t = 0; t <= end_t; t++) begin
            check_val("grant_ack", bus.grant_ack, (t == 0) ? oh : '0);
            check_val("start_tx", bus.ctrl_start_tx, t == 0);
            check_val("tx_done", bus.tx_done, (t == end_t && seen) ? oh : '0);
            check_val("tx_err", bus.tx_err, (t == end_t && !seen) ? oh : '0);
            check_val("arb_busy", bus.arb_busy, t < end_t);
            check_val("data_to_send", bus.ctrl_data_to_send, latched);
            check_val("last_grant", bus.last_grant, exp_idx);
            if (t == 0) begin
                obs = int'(bus.last_grant);
                if (obs >= 0 && obs < N) begin
                    check_val("fair_wait_bound", waits[obs] <= N - 1, 1'b1);
                    waits[obs] = 0;
                    for (int i = 0; i < N; i++) if (snap[i] && i != obs) waits[i]++;
                end
                if (!hold) pending[exp_idx] = 1'b0;
                if (chg) words[exp_idx] = '1;
                drive_req();
            end
            bus.ctrl_tx_busy = (d >= 0) && (t >= d) && (t < d + len);
            if (t < end_t) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        model_last = exp_idx;
    endtask

    initial begin
        int obs;
        int d;
        int len;
        int r;
        bit hold;
        bit chg;
        bus.req          = '0;
        bus.req_data     = '0;
        bus.ctrl_tx_busy = 1'b0;
        pending          = '0;
        model_last       = N - 1;
        for (int i = 0; i < N; i++) begin
            words[i] = '0;
            waits[i] = 0;
        end
        @(negedge clk);
        do_reset();

        // Single request from requester 1.
        pending  = 4'b0010;
        words[1] = 16'hA55A;
        run_txn(1, 20, 1'b0, 1'b0, obs);
        check_val("single_idx", obs, 1);

        // All four at once, each dropping on its acknowledge.
        do_reset();
        pending = 4'b1111;
        for (int i = 0; i < N; i++) words[i] = W'($urandom);
        for (int k = 0; k < N; k++) begin
            run_txn(2, 3, 1'b0, 1'b0, obs);
            check_val("simul_order", obs, k);
        end

        // Requesters 0 and 2 held high permanently.
        pending  = 4'b0101;
        words[0] = W'($urandom);
        words[2] = W'($urandom);
        for (int k = 0; k < 6; k++) begin
            run_txn(1, 2, 1'b1, 1'b0, obs);
            check_val("fair_order", obs, (k % 2) * 2);
        end

        // Controller never goes busy.
        pending  = 4'b0100;
        words[2] = W'($urandom);
        run_txn(-1, 0, 1'b0, 1'b0, obs);
        check_val("timeout_idx", obs, 2);
        idle_quiet(2);

        // Word changes right after the acknowledge.
        pending  = 4'b0001;
        words[0] = 16'h1234;
        run_txn(1, 4, 1'b0, 1'b1, obs);
        check_val("iso_idx", obs, 0);

        // Reset while waiting for the controller to finish.
        pending  = 4'b0001;
        words[0] = 16'hBEEF;
        drive_req();
        @(posedge clk);
        @(negedge clk);
        check_val("mid_grant_ack", bus.grant_ack, 4'b0001);
        pending = '0;
        drive_req();
        bus.ctrl_tx_busy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("mid_arb_busy", bus.arb_busy, 1'b1);
        do_reset();
        idle_quiet(3);
        pending  = 4'b0001;
        words[0] = W'($urandom);
        run_txn(1, 2, 1'b0, 1'b0, obs);
        check_val("post_reset_idx", obs, 0);

        // Randomized traffic.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) idle_quiet($urandom_range(1, 3));
            for (int i = 0; i < N; i++) begin
                if (pending[i] && $urandom_range(0, 7) == 0) begin
                    pending[i] = 1'b0;
                    waits[i]   = 0;
                end else if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    words[i]   = W'($urandom);
                end
            end
            if (pending == '0) begin
                r          = $urandom_range(0, N - 1);
                pending[r] = 1'b1;
                words[r]   = W'($urandom);
            end
            r = $urandom_range(0, 9);
            if (r == 0) begin
                d = -1; len = 0;
            end else if (r == 1) begin
                d = TO - 1; len = $urandom_range(1, 4);
            end else if (r == 2) begin
                d = TO; len = 1;
            end else begin
                d = $urandom_range(1, 5); len = $urandom_range(1, 6);
            end
            hold = ($urandom_range(0, 3) == 0);
            chg  = ($urandom_range(0, 1) == 1);
            run_txn(d, len, hold, chg, obs);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one multi-byte UART transmit controller among N_REQ independent requesters.
- Each requester presents a BYTES-wide word. The arbiter grants one requester, latches its word and pulses the controller's start input. It then tracks the controller's busy flag and reports completion or timeout back to the granted requester.
- Sits between the application logic and the UART controller's data_to_send / start_tx / tx_busy_total interface.

Parameters:
- N_REQ, 4, number of requesters; minimum 2.
- BYTES, 2, word width in bytes; must match the downstream UART controller.
- TIMEOUT, 15, maximum cycles spent waiting for the controller's busy flag to rise after a start pulse; minimum 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level.
- req_data  in  N_REQ*BYTES*8  per-requester word; requester i occupies bits [i*BYTES*8 +: BYTES*8].
- grant_ack  out  N_REQ  one-cycle pulse: word of requester i latched.
- tx_done  out  N_REQ  one-cycle pulse: word of requester i fully transmitted.
- tx_err  out  N_REQ  one-cycle pulse: controller never went busy (timeout).
- ctrl_data_to_send  out  BYTES*8  latched word driven to the controller.
- ctrl_start_tx  out  1  one-cycle start pulse to the controller.
- ctrl_tx_busy  in  1  controller busy flag (tx_busy_total).
- arb_busy  out  1  high whenever state is not IDLE.
- last_grant  out  max(1,$clog2(N_REQ))  index of the most recent grant.

Behaviour:
- Reset:
  - state=IDLE.
  - grant_ack, tx_done, tx_err, ctrl_start_tx = 0.
  - ctrl_data_to_send = 0; timer = 0.
  - last_grant = N_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - req is sampled only in this state.
  - If any req bit is set, select the first set bit searching last_grant+1, last_grant+2, ..., wrapping modulo N_REQ.
  - Next edge: ctrl_data_to_send <= that requester's word; last_grant <= index; grant_ack[index] <= 1; ctrl_start_tx <= 1; timer <= 0; state <= WAIT_BUSY.
  - With req seen in cycle k, grant_ack and ctrl_start_tx are both high in cycle k+1 only.
- WAIT_BUSY:
  - ctrl_start_tx and grant_ack return to 0.
  - If ctrl_tx_busy=1, state <= WAIT_DONE.
  - Else timer increments. When timer==TIMEOUT-1 with busy still low: tx_err[last_grant] pulses, state <= IDLE.
  - Timer width is $clog2(TIMEOUT+1). The timer never wraps.
- WAIT_DONE:
  - When ctrl_tx_busy=0, tx_done[last_grant] pulses for one cycle and state <= IDLE.
  - A new grant may be issued in the cycle where tx_done is high, which gives back-to-back throughput.
- Requester protocol:
  - Hold req and req_data stable until grant_ack is seen, then deassert req in that cycle or the next.
  - A req still high when IDLE is next re-entered is treated as a new request.
  - Dropping req before grant_ack withdraws the request with no side effects.
- req_data changes after the latch edge do not affect ctrl_data_to_send.
- At most one bit of grant_ack, tx_done and tx_err is set in any cycle; the three are never set together for the same index.
- A single requester asserting continuously is served every transaction. No requester waits more than N_REQ-1 other transactions.
- Reset asserted in any state returns to IDLE on the next edge with all pulses cleared. In-flight completion is not reported. The top level resets the controller concurrently.
- ctrl_tx_busy high while in IDLE is ignored; no grant is withheld for it.

Test Plan:
- Single request: req=0b0010, req_data[1]=16'hA55A, controller model busy for 20 cycles after start.
  - Expect grant_ack=0b0010 and ctrl_start_tx high in the cycle after req.
  - Expect ctrl_data_to_send=16'hA55A.
  - Expect tx_done=0b0010 one cycle after busy falls.
- Simultaneous: req=0b1111 held; each requester drops req on its ack.
  - Expect grants in order 0,1,2,3.
  - Expect tx_done pulses in that same order, with no overlap.
- Fairness: req0 and req2 held high permanently for 6 transactions.
  - Expect grants 0,2,0,2,0,2.
  - Expect last_grant to track each grant.
- Timeout: ctrl_tx_busy tied 0, req=0b0100.
  - Expect tx_err=0b0100 exactly TIMEOUT cycles after ctrl_start_tx.
  - Expect no tx_done.
  - Expect arb_busy low in the following cycle.
- Data isolation: change req_data[0] from 16'h1234 to 16'hFFFF one cycle after grant_ack.
  - Expect ctrl_data_to_send to hold 16'h1234 through tx_done.
- Reset mid-operation: assert reset for 1 cycle during WAIT_DONE.
  - Expect all outputs zero and last_grant=N_REQ-1 next cycle.
  - Expect no tx_done.
  - Expect the next req=0b0001 to be granted normally.
